// File: rtl/mmc_cmd_pkg.sv
// Shared constants for the MMC/SD SPI command sequencers: state codes, frame bytes, block size.
package mmc_cmd_pkg;

  localparam logic [3:0] ST_IDLE      = 4'd0;
  localparam logic [3:0] ST_CMD       = 4'd1;
  localparam logic [3:0] ST_RESP_REQ  = 4'd2;
  localparam logic [3:0] ST_RESP_GET  = 4'd3;
  localparam logic [3:0] ST_TOKEN_REQ = 4'd4;
  localparam logic [3:0] ST_TOKEN_GET = 4'd5;
  localparam logic [3:0] ST_DATA_REQ  = 4'd6;
  localparam logic [3:0] ST_DATA_GET  = 4'd7;
  localparam logic [3:0] ST_CRC_REQ   = 4'd8;
  localparam logic [3:0] ST_CRC_GET   = 4'd9;
  localparam logic [3:0] ST_DUMMY_REQ = 4'd10;
  localparam logic [3:0] ST_DUMMY_GET = 4'd11;
  localparam logic [3:0] ST_END       = 4'd12;

  localparam logic [7:0] CMD17_OPCODE = 8'h51;
  localparam logic [7:0] CMD_STOP     = 8'h01;
  localparam logic [7:0] START_TOKEN  = 8'hFE;
  localparam logic [7:0] DUMMY_BYTE   = 8'hFF;
  localparam int         BLOCK_BYTES  = 512;

  // Data error token: upper nibble clear, some error bit set.
  function automatic logic is_err_token(input logic [7:0] b);
    return (b[7:4] == 4'h0) && (b != 8'h00);
  endfunction

endpackage

// File: rtl/mmc_crc16_byte.sv
// One-byte step of CRC16-CCITT (poly 0x1021), MSB first, purely combinational.
module mmc_crc16_byte (
  input  logic [15:0] i_crc,
  input  logic [7:0]  i_byte,
  output logic [15:0] o_crc
);

  always_comb begin
    o_crc = i_crc ^ {i_byte, 8'h00};
    for (int b = 0; b < 8; b++)
      o_crc = o_crc[15] ? ((o_crc << 1) ^ 16'h1021) : (o_crc << 1);
  end

endmodule

// File: rtl/mmc_cmd_control_layer_cmd17.sv
// CMD17 single-block read sequencer: command frame, R1/token polling, 512-byte capture into a 128x32 buffer.
// Define MMC_CMD17_CRC_CHECK_EN to check the block CRC16 and flag mismatches on oCMD_ERR.
module mmc_cmd_control_layer_cmd17
  import mmc_cmd_pkg::*;
#(
  parameter int P_DATA_BYTES = BLOCK_BYTES
) (
  input  logic        iCLOCK,
  input  logic        inRESET,
  input  logic        iRESET_SYNC,
  input  logic        iCMD_START,
  input  logic [31:0] iCMD_ADDR,
  output logic        oCMD_END,
  output logic        oCMD_ERR,
  output logic        oBUFF_WE,
  output logic [6:0]  oBUFF_ADDR,
  output logic [31:0] oBUFF_DATA,
  output logic        oMMC_REQ,
  input  logic        iMMC_BUSY,
  output logic        oMMC_CS,
  output logic [7:0]  oMMC_DATA,
  input  logic        iMMC_VALID,
  input  logic [7:0]  iMMC_DATA,
  input  logic        iMMC_INFO_MISO
);

  logic [3:0]  r_state, w_next;
  logic [9:0]  r_count;
  logic [31:0] r_addr;
  logic [31:0] r_word;
  logic        r_err;
  logic        w_is_req;
  logic        w_accept;
  logic [31:0] w_word_merged;
  logic        w_crc_bad;
  logic        w_unused;

  assign w_unused = iMMC_INFO_MISO;

  assign w_is_req = (r_state == ST_CMD)      || (r_state == ST_RESP_REQ) ||
                    (r_state == ST_TOKEN_REQ) || (r_state == ST_DATA_REQ) ||
                    (r_state == ST_CRC_REQ)   || (r_state == ST_DUMMY_REQ);
  assign w_accept = w_is_req && !iMMC_BUSY;

`ifdef MMC_CMD17_CRC_CHECK_EN
  logic [15:0] r_crc, w_crc_next;
  logic [7:0]  r_crc_b0;

  mmc_crc16_byte u_crc (
    .i_crc  (r_crc),
    .i_byte (iMMC_DATA),
    .o_crc  (w_crc_next)
  );

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      r_crc    <= '0;
      r_crc_b0 <= '0;
    end else if (iRESET_SYNC) begin
      r_crc    <= '0;
      r_crc_b0 <= '0;
    end else begin
      if (r_state == ST_IDLE && iCMD_START)
        r_crc <= '0;
      else if (r_state == ST_DATA_GET && iMMC_VALID)
        r_crc <= w_crc_next;
      if (r_state == ST_CRC_GET && iMMC_VALID && r_count[0] == 1'b0)
        r_crc_b0 <= iMMC_DATA;
    end
  end

  // First CRC byte received is the high byte.
  assign w_crc_bad = (r_state == ST_CRC_GET) && iMMC_VALID && r_count[0] &&
                     ({r_crc_b0, iMMC_DATA} != r_crc);
`else
  assign w_crc_bad = 1'b0;
`endif

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET)         r_state <= ST_IDLE;
    else if (iRESET_SYNC) r_state <= ST_IDLE;
    else                  r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:      if (iCMD_START) w_next = ST_CMD;
      // Leave on the sixth accepted byte so no seventh request is issued.
      ST_CMD:       if (r_count >= 10'd6 || (w_accept && r_count == 10'd5)) w_next = ST_RESP_REQ;
      ST_RESP_REQ:  if (w_accept) w_next = ST_RESP_GET;
      ST_RESP_GET:
        if (iMMC_VALID) begin
          if (iMMC_DATA == 8'hFF)      w_next = ST_RESP_REQ;
          else if (iMMC_DATA == 8'h00) w_next = ST_TOKEN_REQ;
          else                         w_next = ST_DUMMY_REQ;
        end
      ST_TOKEN_REQ: if (w_accept) w_next = ST_TOKEN_GET;
      ST_TOKEN_GET:
        if (iMMC_VALID) begin
          if (iMMC_DATA == START_TOKEN)     w_next = ST_DATA_REQ;
          else if (is_err_token(iMMC_DATA)) w_next = ST_DUMMY_REQ;
          else                              w_next = ST_TOKEN_REQ;
        end
      ST_DATA_REQ:  if (w_accept) w_next = ST_DATA_GET;
      ST_DATA_GET:
        if (iMMC_VALID)
          w_next = (r_count == 10'(P_DATA_BYTES - 1)) ? ST_CRC_REQ : ST_DATA_REQ;
      ST_CRC_REQ:   if (w_accept) w_next = ST_CRC_GET;
      ST_CRC_GET:   if (iMMC_VALID) w_next = r_count[0] ? ST_DUMMY_REQ : ST_CRC_REQ;
      ST_DUMMY_REQ: if (w_accept) w_next = ST_DUMMY_GET;
      ST_DUMMY_GET: if (iMMC_VALID) w_next = ST_END;
      ST_END:       w_next = ST_IDLE;
      default:      w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      r_count <= '0;
      r_addr  <= '0;
      r_word  <= '0;
      r_err   <= 1'b0;
    end else if (iRESET_SYNC) begin
      r_count <= '0;
      r_addr  <= '0;
      r_word  <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE:
          if (iCMD_START) begin
            r_addr  <= iCMD_ADDR;
            r_count <= '0;
            r_err   <= 1'b0;
          end
        ST_CMD:
          if (w_accept) r_count <= r_count + 10'd1;
        ST_RESP_GET:
          if (iMMC_VALID && iMMC_DATA != 8'hFF && iMMC_DATA != 8'h00) r_err <= 1'b1;
        ST_TOKEN_GET:
          if (iMMC_VALID) begin
            if (iMMC_DATA == START_TOKEN)     r_count <= '0;
            else if (is_err_token(iMMC_DATA)) r_err   <= 1'b1;
          end
        ST_DATA_GET:
          if (iMMC_VALID) begin
            r_word  <= w_word_merged;
            r_count <= (r_count == 10'(P_DATA_BYTES - 1)) ? 10'd0 : r_count + 10'd1;
          end
        ST_CRC_GET:
          if (iMMC_VALID) begin
            r_count <= r_count + 10'd1;
            if (w_crc_bad) r_err <= 1'b1;
          end
        default: ;
      endcase
    end
  end

  // The byte arriving now completes the word, so the write uses the merged value.
  always_comb begin
    w_word_merged = r_word;
    w_word_merged[{r_count[1:0], 3'b000} +: 8] = iMMC_DATA;
  end

  always_comb begin
    oMMC_REQ   = w_accept;
    oMMC_CS    = (r_state == ST_IDLE) || (r_state == ST_END);
    oMMC_DATA  = DUMMY_BYTE;
    if (r_state == ST_CMD) begin
      case (r_count[2:0])
        3'd0:    oMMC_DATA = CMD17_OPCODE;
        3'd1:    oMMC_DATA = r_addr[31:24];
        3'd2:    oMMC_DATA = r_addr[23:16];
        3'd3:    oMMC_DATA = r_addr[15:8];
        3'd4:    oMMC_DATA = r_addr[7:0];
        3'd5:    oMMC_DATA = CMD_STOP;
        default: oMMC_DATA = DUMMY_BYTE;
      endcase
    end
    oBUFF_WE   = (r_state == ST_DATA_GET) && iMMC_VALID && (r_count[1:0] == 2'd3);
    oBUFF_ADDR = r_count[8:2];
    oBUFF_DATA = w_word_merged;
    oCMD_END   = (r_state == ST_END);
    oCMD_ERR   = (r_state == ST_END) && r_err;
  end

endmodule

// File: tb/tb_mmc_cmd_control_layer_cmd17.sv
// Bench for the CMD17 sequencer: scripted card + byte transfer layer, protocol-level expectation model.
module tb_mmc_cmd_control_layer_cmd17;

  typedef logic [7:0] byte_q_t[$];
  typedef struct { logic [6:0] a; logic [31:0] d; } wr_t;

  logic        iCLOCK = 1'b0;
  logic        inRESET = 1'b0;
  logic        iRESET_SYNC = 1'b0;
  logic        iCMD_START = 1'b0;
  logic [31:0] iCMD_ADDR = '0;
  logic        oCMD_END, oCMD_ERR, oBUFF_WE, oMMC_REQ, oMMC_CS;
  logic [6:0]  oBUFF_ADDR;
  logic [31:0] oBUFF_DATA;
  logic [7:0]  oMMC_DATA;
  logic        iMMC_BUSY = 1'b0;
  logic        iMMC_VALID = 1'b0;
  logic [7:0]  iMMC_DATA = 8'hFF;
  logic        iMMC_INFO_MISO = 1'b1;

  mmc_cmd_control_layer_cmd17 dut (
    .iCLOCK(iCLOCK), .inRESET(inRESET), .iRESET_SYNC(iRESET_SYNC),
    .iCMD_START(iCMD_START), .iCMD_ADDR(iCMD_ADDR),
    .oCMD_END(oCMD_END), .oCMD_ERR(oCMD_ERR),
    .oBUFF_WE(oBUFF_WE), .oBUFF_ADDR(oBUFF_ADDR), .oBUFF_DATA(oBUFF_DATA),
    .oMMC_REQ(oMMC_REQ), .iMMC_BUSY(iMMC_BUSY), .oMMC_CS(oMMC_CS),
    .oMMC_DATA(oMMC_DATA), .iMMC_VALID(iMMC_VALID), .iMMC_DATA(iMMC_DATA),
    .iMMC_INFO_MISO(iMMC_INFO_MISO)
  );

  always #5 iCLOCK = ~iCLOCK;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Expectation model state
  logic [7:0] cmd_bytes [6];
  wr_t        exp_wr[$];
  logic       exp_err;
  int         exp_reqs;
  // Transfer layer / card state
  byte_q_t    rx_q;
  bit         pend = 0;
  int         dly = 0;
  logic [7:0] rx_pend = 8'hFF;
  int         bmax = 0;
  int         act_reqs = 0, act_wr = 0, act_end = 0;

  // Bit-serial CRC16-CCITT over the whole block, init 0.
  function automatic logic [15:0] crc16(input byte_q_t d);
    logic [15:0] c = 16'h0000;
    foreach (d[i])
      for (int b = 7; b >= 0; b--)
        c = {c[14:0], 1'b0} ^ ((c[15] ^ d[i][b]) ? 16'h1021 : 16'h0000);
    return c;
  endfunction

  // Walk the card script as the protocol dictates and derive expected traffic.
  function automatic void build_model(input logic [31:0] a, input byte_q_t s);
    int ph = 0;
    int i = 0;
    logic [7:0] b;
    byte_q_t dat;
    byte_q_t crc_rx;
    cmd_bytes = '{8'h51, a[31:24], a[23:16], a[15:8], a[7:0], 8'h01};
    exp_wr.delete();
    exp_err = 1'b0;
    while (ph < 5 && i < 4096) begin
      b = (i < s.size()) ? s[i] : 8'hFF;
      i++;
      case (ph)
        0: if (b == 8'h00) ph = 1; else if (b != 8'hFF) begin exp_err = 1'b1; ph = 4; end
        1: if (b == 8'hFE) ph = 2; else if (b != 8'h00 && b < 8'h10) begin exp_err = 1'b1; ph = 4; end
        2: begin dat.push_back(b); if (dat.size() == 512) ph = 3; end
        3: begin
          crc_rx.push_back(b);
          if (crc_rx.size() == 2) begin
`ifdef MMC_CMD17_CRC_CHECK_EN
            if ({crc_rx[0], crc_rx[1]} != crc16(dat)) exp_err = 1'b1;
`endif
            ph = 4;
          end
        end
        default: ph = 5;
      endcase
    end
    exp_reqs = 6 + i;
    for (int w = 0; w < dat.size() / 4; w++)
      exp_wr.push_back('{7'(w), {dat[4*w+3], dat[4*w+2], dat[4*w+1], dat[4*w]}});
  endfunction

  function automatic byte_q_t mk_clean(input int mul, input int add, input logic [7:0] crc_flip);
    byte_q_t s;
    byte_q_t dat;
    logic [15:0] c;
    s = '{8'hFF, 8'hFF, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFE};
    for (int k = 0; k < 512; k++) dat.push_back(8'((k * mul + add) & 255));
    c = crc16(dat);
    foreach (dat[k]) s.push_back(dat[k]);
    s.push_back(c[15:8]);
    s.push_back(c[7:0] ^ crc_flip);
    s.push_back(8'hFF);
    return s;
  endfunction

  // Transfer layer + every-cycle compare process.
  initial begin
    wr_t e;
    forever begin
      @(negedge iCLOCK);
      if (pend) begin
        if (dly > 0) begin iMMC_BUSY = 1'b1; iMMC_VALID = 1'b0; dly--; end
        else begin iMMC_BUSY = 1'b0; iMMC_VALID = 1'b1; iMMC_DATA = rx_pend; pend = 0; end
      end else begin
        iMMC_BUSY = 1'b0; iMMC_VALID = 1'b0; iMMC_DATA = 8'hFF;
      end
      #1;
      if (oMMC_REQ) begin
        chk("req_while_busy", 32'(iMMC_BUSY), 32'd0);
        chk("mosi", 32'(oMMC_DATA), (act_reqs < 6) ? 32'(cmd_bytes[act_reqs]) : 32'hFF);
        chk("cs_low", 32'(oMMC_CS), 32'd0);
        act_reqs++;
        pend = 1;
        dly = (bmax > 0) ? int'($urandom_range(bmax, 0)) : 0;
        rx_pend = (rx_q.size() > 0) ? rx_q.pop_front() : 8'hFF;
      end
      if (oBUFF_WE) begin
        act_wr++;
        if (exp_wr.size() == 0) chk("extra_write", 32'd1, 32'd0);
        else begin
          e = exp_wr.pop_front();
          chk("wr_addr", 32'(oBUFF_ADDR), 32'(e.a));
          chk("wr_data", oBUFF_DATA, e.d);
        end
      end
      if (oCMD_END) begin
        act_end++;
        chk("cmd_err", 32'(oCMD_ERR), 32'(exp_err));
        chk("cs_end", 32'(oMMC_CS), 32'd1);
      end
    end
  end

  task automatic run_block(input string nm, input logic [31:0] addr, input byte_q_t scr,
                           input int bm, input bit extra_start, input int abort_words);
    int cyc;
    int n_wr;
    build_model(addr, scr);
    n_wr = exp_wr.size();
    rx_q.delete();
    repeat (6) rx_q.push_back(8'hFF);
    foreach (scr[k]) rx_q.push_back(scr[k]);
    bmax = bm; act_reqs = 0; act_wr = 0; act_end = 0;
    @(negedge iCLOCK); #2;
    iCMD_ADDR = addr; iCMD_START = 1'b1;
    @(negedge iCLOCK); #2;
    iCMD_START = 1'b0; iCMD_ADDR = ~addr;
    if (extra_start) begin
      repeat (3) @(negedge iCLOCK);
      #2 iCMD_START = 1'b1;
      @(negedge iCLOCK); #2 iCMD_START = 1'b0;
    end
    cyc = 0;
    if (abort_words > 0) begin
      while (act_wr < abort_words && cyc < 30000) begin @(negedge iCLOCK); cyc++; end
      chk({nm, "_abort_reach"}, 32'(act_wr), 32'(abort_words));
      #2 iRESET_SYNC = 1'b1;
      @(negedge iCLOCK); #2 iRESET_SYNC = 1'b0;
      chk({nm, "_abort_cs"}, 32'(oMMC_CS), 32'd1);
      chk({nm, "_abort_req"}, 32'(oMMC_REQ), 32'd0);
      pend = 0; rx_q.delete();
      repeat (30) @(negedge iCLOCK);
      chk({nm, "_abort_no_end"}, 32'(act_end), 32'd0);
      exp_wr.delete();
    end else begin
      while (act_end == 0 && cyc < 30000) begin @(negedge iCLOCK); cyc++; end
      repeat (4) @(negedge iCLOCK);
      #2;
      chk({nm, "_end_count"}, 32'(act_end), 32'd1);
      chk({nm, "_req_count"}, 32'(act_reqs), 32'(exp_reqs));
      chk({nm, "_wr_count"}, 32'(act_wr), 32'(n_wr));
      chk({nm, "_cs_idle"}, 32'(oMMC_CS), 32'd1);
    end
  endtask

  initial begin
    byte_q_t s;
    byte_q_t p;
    repeat (3) @(negedge iCLOCK);
    #2;
    chk("rst_cs", 32'(oMMC_CS), 32'd1);
    chk("rst_end", 32'(oCMD_END), 32'd0);
    chk("rst_err", 32'(oCMD_ERR), 32'd0);
    chk("rst_we", 32'(oBUFF_WE), 32'd0);
    chk("rst_req", 32'(oMMC_REQ), 32'd0);
    inRESET = 1'b1;
    repeat (2) @(negedge iCLOCK);

    // Pin the model against hand-computed values.
    p = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    chk("pin_crc_check", 32'(crc16(p)), 32'h31C3);
    s = mk_clean(1, 0, 8'h00);
    build_model(32'h00001200, s);
    chk("pin_word0", exp_wr[0].d, 32'h03020100);
    chk("pin_word127", exp_wr[127].d, 32'hFFFEFDFC);
    chk("pin_nwords", 32'(exp_wr.size()), 32'd128);
    chk("pin_reqs", 32'(exp_reqs), 32'd528);
    build_model(32'h0, '{8'h05, 8'hFF});
    chk("pin_r1err_reqs", 32'(exp_reqs), 32'd8);
    chk("pin_r1err_err", 32'(exp_err), 32'd1);

    run_block("clean", 32'h00001200, mk_clean(1, 0, 8'h00), 0, 1'b0, 0);
    run_block("r1_err", 32'h00000400, '{8'hFF, 8'h05, 8'hFF}, 2, 1'b0, 0);
    run_block("tok_err", 32'h00000800, '{8'hFF, 8'h00, 8'hFF, 8'h08, 8'hFF}, 0, 1'b0, 0);
    run_block("busy", 32'hDEADBEEF, mk_clean(1, 0, 8'h00), 5, 1'b1, 0);
    run_block("abort", 32'h12345678, mk_clean(3, 7, 8'h00), 1, 1'b0, 40);
    run_block("recover", 32'hA5A50F0F, mk_clean(7, 3, 8'h00), 3, 1'b0, 0);
    run_block("bad_crc", 32'h00000001, mk_clean(5, 1, 8'h01), 0, 1'b0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
